// File: rtl/div_radix4_srt.sv
// Iterative radix-4 SRT divider: dout = floor(din_x * 2^WF / din_d) for unsigned 1.WF operands.
// Two quotient bits per enabled clock; digit selection thresholds come from four loadable tables.
module div_radix4_srt #(
  parameter int WL           = 24,
  parameter int WF           = 23,
  parameter int RADIX        = 4,
  parameter int N            = 12,
  parameter int LUT_size     = 8,
  parameter int LUT_bits     = 7,
  parameter int LUT_addWidth = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          CE,
  input  logic [WL-1:0] din_x,
  input  logic [WL-1:0] din_d,
  output logic [WL-1:0] dout
);

  // Remainder: sign + 2 integer bits + (WF+1) fraction bits, so x/2 is exact.
  localparam int RW    = WF + 4;
  localparam int SH    = $clog2(RADIX);
  localparam int IDX_W = $clog2(LUT_size);
  localparam int CNT_W = (LUT_addWidth > $clog2(N)) ? LUT_addWidth : $clog2(N);

  reg signed [LUT_bits-1:0] LUT_m2  [0:LUT_size-1] = '{7'sd12, 7'sd14, 7'sd15, 7'sd16,
                                                       7'sd18, 7'sd20, 7'sd20, 7'sd24};
  reg signed [LUT_bits-1:0] LUT_m1  [0:LUT_size-1] = '{7'sd4, 7'sd4, 7'sd4, 7'sd4,
                                                       7'sd6, 7'sd6, 7'sd8, 7'sd8};
  reg signed [LUT_bits-1:0] LUT_m0  [0:LUT_size-1] = '{-7'sd4, -7'sd6, -7'sd6, -7'sd6,
                                                       -7'sd6, -7'sd8, -7'sd8, -7'sd8};
  reg signed [LUT_bits-1:0] LUT_mm1 [0:LUT_size-1] = '{-7'sd13, -7'sd15, -7'sd16, -7'sd18,
                                                       -7'sd20, -7'sd20, -7'sd22, -7'sd24};

  logic [CNT_W-1:0]           cnt_r;
  logic [RW-1:0]              w_r;
  logic [WL-1:0]              d_r;
  logic [WL-1:0]              q_r;
  logic [WL-1:0]              qm_r;

  logic                       first_s;
  logic [WL-1:0]              d_s;
  logic [RW-1:0]              dd_s;
  logic [RW-1:0]              w_s;
  logic [RW-1:0]              w4_s;
  logic signed [LUT_bits-1:0] y_s;
  logic [IDX_W-1:0]           idx_s;
  logic [2:0]                 digit_s;
  logic [RW-1:0]              w_nxt_s;
  logic [WL-1:0]              qb_s;
  logic [WL-1:0]              qmb_s;
  logic [WL-1:0]              q_nxt_s;
  logic [WL-1:0]              qm_nxt_s;

  // One SRT iteration: digit selection, remainder update and on-the-fly quotient conversion.
  always_comb begin
    first_s = (cnt_r == '0);
    d_s     = first_s ? din_d : d_r;
    dd_s    = {{(RW-WL-1){1'b0}}, d_s, 1'b0};
    w_s     = first_s ? {{(RW-WL){1'b0}}, din_x} : w_r;
    qb_s    = first_s ? '0 : q_r;
    qmb_s   = first_s ? '0 : qm_r;
    w4_s    = w_s << SH;
    y_s     = w4_s[RW-1 -: LUT_bits];
    idx_s   = d_s[WF-2 -: IDX_W];

    if (y_s >= LUT_m2[idx_s]) begin
      digit_s = 3'b010;
    end else if (y_s >= LUT_m1[idx_s]) begin
      digit_s = 3'b001;
    end else if (y_s >= LUT_m0[idx_s]) begin
      digit_s = 3'b000;
    end else if (y_s >= LUT_mm1[idx_s]) begin
      digit_s = 3'b111;
    end else begin
      digit_s = 3'b110;
    end

    case (digit_s)
      3'b010: begin
        w_nxt_s  = w4_s - (dd_s << 1);
        q_nxt_s  = (qb_s << SH) + WL'(2);
        qm_nxt_s = (qb_s << SH) + WL'(1);
      end
      3'b001: begin
        w_nxt_s  = w4_s - dd_s;
        q_nxt_s  = (qb_s << SH) + WL'(1);
        qm_nxt_s = qb_s << SH;
      end
      3'b111: begin
        w_nxt_s  = w4_s + dd_s;
        q_nxt_s  = (qmb_s << SH) + WL'(3);
        qm_nxt_s = (qmb_s << SH) + WL'(2);
      end
      3'b110: begin
        w_nxt_s  = w4_s + (dd_s << 1);
        q_nxt_s  = (qmb_s << SH) + WL'(2);
        qm_nxt_s = (qmb_s << SH) + WL'(1);
      end
      default: begin
        w_nxt_s  = w4_s;
        q_nxt_s  = qb_s << SH;
        qm_nxt_s = (qmb_s << SH) + WL'(3);
      end
    endcase
  end

  // Frame sequencing and state; a negative final remainder selects QM.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt_r <= '0;
      w_r   <= '0;
      d_r   <= '0;
      q_r   <= '0;
      qm_r  <= '0;
      dout  <= '0;
    end else if (CE) begin
      w_r  <= w_nxt_s;
      q_r  <= q_nxt_s;
      qm_r <= qm_nxt_s;
      if (first_s) begin
        d_r <= din_d;
      end
      if (cnt_r == CNT_W'(N-1)) begin
        cnt_r <= '0;
        dout  <= w_nxt_s[RW-1] ? qm_nxt_s : q_nxt_s;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_div_radix4_srt.sv
// Self-checking bench for div_radix4_srt: vector table, CE pause, mid-frame reset and random frames.
module tb_div_radix4_srt;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        CE;
  logic [23:0] din_x;
  logic [23:0] din_d;
  logic [23:0] dout;

  int errors = 0;
  int checks = 0;
  int fcnt   = 0;
  logic [23:0] dout_exp = 24'h000000;
  logic [23:0] sb_q[$];

  typedef struct {
    logic [23:0] x;
    logic [23:0] d;
    logic [23:0] q;
  } vec_t;
  vec_t vecs[7];

  div_radix4_srt u_dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .CE    (CE),
    .din_x (din_x),
    .din_d (din_d),
    .dout  (dout)
  );

  always #5 CLK = ~CLK;

  function automatic logic [23:0] ref_div(input logic [23:0] x, input logic [23:0] d);
    logic [63:0] num;
    num = {40'd0, x} << 23;
    return 24'(num / {40'd0, d});
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: advance the bench's frame model, then compare dout just after the edge.
  task automatic step();
    @(posedge CLK);
    if (!nRST) begin
      sb_q.delete();
      fcnt     = 0;
      dout_exp = 24'h000000;
    end else if (CE) begin
      if (fcnt == 11) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
          dout_exp = sb_q.pop_front();
        end
        fcnt = 0;
      end else begin
        fcnt++;
      end
    end
    #1;
    check("dout", dout, dout_exp);
  endtask

  task automatic scramble();
    din_x = 24'($urandom());
    din_d = 24'($urandom());
  endtask

  task automatic run_frame(input logic [23:0] x, input logic [23:0] d, input logic [23:0] q);
    din_x = x;
    din_d = d;
    sb_q.push_back(q);
    step();
    scramble();
    repeat (11) step();
  endtask

  initial begin
    logic [23:0] rx;
    logic [23:0] rd;

    vecs[0] = '{24'h333333, 24'h599999, 24'h492492};
    vecs[1] = '{24'h133333, 24'h5851EB, 24'h1BD37A};
    vecs[2] = '{24'h5EB851, 24'h7EB851, 24'h5FAD40};
    vecs[3] = '{24'h000000, 24'h600000, 24'h000000};
    vecs[4] = '{24'h3FFFFF, 24'h400000, 24'h7FFFFE};
    vecs[5] = '{24'h7FFFFE, 24'h7FFFFF, 24'h7FFFFE};
    vecs[6] = '{24'h000001, 24'h400000, 24'h000002};

    nRST  = 1'b0;
    CE    = 1'b1;
    din_x = 24'h333333;
    din_d = 24'h599999;
    step();
    step();
    check("reset_cnt", 24'(u_dut.cnt_r), 24'h000000);

    nRST = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].x, vecs[i].d, vecs[i].q);
    end

    // CE dropped for 5 cycles mid-frame with inputs changing meanwhile.
    din_x = 24'h333333;
    din_d = 24'h599999;
    sb_q.push_back(24'h492492);
    step();
    scramble();
    repeat (3) step();
    CE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      scramble();
      step();
    end
    check("pause_cnt", 24'(u_dut.cnt_r), 24'h000004);
    CE = 1'b1;
    repeat (8) step();

    // Reset asserted with cnt = 6 discards the frame.
    run_frame(vecs[1].x, vecs[1].d, vecs[1].q);
    din_x = 24'h333333;
    din_d = 24'h599999;
    sb_q.push_back(24'h492492);
    step();
    repeat (5) step();
    check("mid_cnt", 24'(u_dut.cnt_r), 24'h000006);
    nRST = 1'b0;
    step();
    check("mid_reset_cnt", 24'(u_dut.cnt_r), 24'h000000);
    nRST = 1'b1;
    run_frame(vecs[2].x, vecs[2].d, vecs[2].q);

    for (int i = 0; i < 25; i++) begin
      rd = {2'b01, 22'($urandom())};
      rx = 24'($urandom_range(0, int'(rd) - 1));
      run_frame(rx, rd, ref_div(rx, rd));
    end

    check("sb_drained", 24'(sb_q.size()), 24'h000000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
